// File: rtl/nor_gate_pkg.sv
// rtl/nor_gate_pkg.sv - shared constants, types and helpers for the NOR gate cell
package nor_gate_pkg;

  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] nor_word_t;

  localparam nor_word_t RESET_WORD = '0;

  // Bits needed to hold a count of 0..w set lanes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nor_gate_lane.sv
// rtl/nor_gate_lane.sv - single combinational NOR bit
module nor_gate_lane (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a | b);

endmodule

// File: rtl/nor_gate_core.sv
// rtl/nor_gate_core.sv - WIDTH-lane NOR with combinational tap and registered, valid-qualified output
// Optional NOR_GATE_POPCNT_EN adds a registered ones_cnt of the captured result.
module nor_gate_core
  import nor_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef NOR_GATE_POPCNT_EN
  ,
  output logic [cnt_width(WIDTH)-1:0] ones_cnt
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nor_gate_lane u_lane (
      .a (a[i]),
      .b (b[i]),
      .y (out_comb[i])
    );
  end

  // out holds across invalid cycles; only out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= RESET_WORD[WIDTH-1:0];
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= out_comb;
      end
    end
  end

`ifdef NOR_GATE_POPCNT_EN
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CW'(out_comb[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (in_valid) begin
      ones_cnt <= cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_nor_gate_core.sv
// tb/tb_nor_gate_core.sv - scoreboard bench for nor_gate_core (WIDTH=8 and WIDTH=1 instances)
module tb_nor_gate_core;

  typedef struct {
    logic       v;
    logic [7:0] o;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] out_comb;
  logic [7:0] out;
  logic       out_valid;

  logic       in_valid1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic [0:0] out_comb1;
  logic [0:0] out1;
  logic       out_valid1;

`ifdef NOR_GATE_POPCNT_EN
  logic [3:0] ones_cnt;
  logic [0:0] ones_cnt1;
`endif

  exp_t       sb[$];
  logic       sb1[$];
  logic [7:0] held;
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  nor_gate_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_comb  (out_comb),
    .out       (out),
    .out_valid (out_valid)
`ifdef NOR_GATE_POPCNT_EN
    ,
    .ones_cnt  (ones_cnt)
`endif
  );

  nor_gate_core #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .out_comb  (out_comb1),
    .out       (out1),
    .out_valid (out_valid1)
`ifdef NOR_GATE_POPCNT_EN
    ,
    .ones_cnt  (ones_cnt1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane is 1 only when both operands are 0; invalid cycles keep the last result.
  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic rel);
    logic [7:0] r;
    exp_t e;
    @(negedge clk);
    if (rel) rst = 1'b0;
    in_valid = v;
    a = av;
    b = bv;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = (av[i] == 1'b0 && bv[i] == 1'b0);
    if (v) held = r;
    e.v = v;
    e.o = held;
    e.c = $countones(held);
    sb.push_back(e);
    #1;
    check("out_comb", out_comb, r);
  endtask

  task automatic drive1(input logic av, input logic bv);
    logic r;
    @(negedge clk);
    in_valid1 = 1'b1;
    a1 = av;
    b1 = bv;
    r = (av == 1'b0) && (bv == 1'b0);
    sb1.push_back(r);
    #1;
    check("out_comb1", out_comb1, r);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_valid", out_valid, e.v);
          check("out", out, e.o);
`ifdef NOR_GATE_POPCNT_EN
          check("ones_cnt", ones_cnt, e.c);
`endif
        end else if (out_valid) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end
        if (sb1.size() > 0) begin
          check("out_valid1", out_valid1, 1'b1);
          check("out1", out1, sb1.pop_front());
        end else if (out_valid1) begin
          check("unexpected_out_valid1", out_valid1, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    held = 8'h00;
    #2;
    check("reset_out", out, 8'h00);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_comb", out_comb, 8'hFF);
    check("reset_out1", out1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 truth table, one combination per cycle
    drive1(1'b0, 1'b0);
    drive1(1'b0, 1'b1);
    drive1(1'b1, 1'b0);
    drive1(1'b1, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0;

    // Vector and hold
    drive(1'b1, 8'hF0, 8'h0C, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    drive(1'b0, 8'h5A, 8'hA5, 1'b0);

    // Async reset between edges while out holds FF
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    held = 8'h00;
    #1;
    check("async_rst_out", out, 8'h00);
    check("async_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h00, 8'h00, 1'b0);

    // Streaming: back-to-back valid random pairs
    for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    // Mixed random valid/invalid
    for (int i = 0; i < 24; i++) drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);

    // Reset released together with a valid input
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    held = 8'h00;
    drive(1'b1, 8'h00, 8'h01, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("sb1_drained", 64'(sb1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_gate_core.md
Name: nor_gate_core

Overview:
- Parameterised bitwise 2-input NOR with a one-cycle registered output and a valid flag.
- Truth table per bit: 00→1, 01→0, 10→0, 11→0.
- Serves as the basic-gate library cell for synchronous datapaths that need a registered NOR stage. A combinational tap is also provided for glue logic.

Parameters:
- WIDTH, 1, number of independent NOR lanes (bits); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- out_comb  output  WIDTH  combinational ~(a|b); ignores in_valid and clk.
- out  output  WIDTH  registered NOR result.
- out_valid  output  1  out holds a result captured on the previous valid cycle.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- out_comb = ~(a | b) bitwise at all times, including during reset.
- Reset values: while rst=1, out = all-zeros and out_valid = 0, immediately and independent of clk.
- Capture: on each rising clk with rst=0:
  - If in_valid=1: out <= ~(a|b) and out_valid <= 1.
  - If in_valid=0: out holds its previous value and out_valid <= 0.
- Latency: exactly 1 cycle from a valid input to out/out_valid. Back-to-back valid inputs give back-to-back results; throughput is 1 per cycle. No backpressure, no ready signal.
- Reset mid-stream: any pending result is discarded. The first valid input after rst deasserts produces out_valid on the following edge.
- rst deasserting on the same edge as in_valid=1: the input is captured normally.
- Lanes are fully independent; no cross-bit logic.
- No X-masking: X/Z on an input propagates per standard operator semantics.

Optional Feature:
- Macro NOR_GATE_POPCNT_EN.
- Defined:
  - Adds output port ones_cnt, width $clog2(WIDTH+1).
  - ones_cnt is registered alongside out and equals the number of 1 bits in ~(a|b) for the captured input.
  - Reset value 0; holds when in_valid=0.
  - Same 1-cycle latency as out.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package nor_gate_pkg:
  - MAX_WIDTH = 64.
  - Function cnt_width(w) returning $clog2(w+1).
  - Typedef for the reset-value constant (all-zeros).
- Sub-module nor_gate_lane: one combinational bit, y = ~(a|b).
  - Instantiated WIDTH times via generate.
  - The register stage and popcount live in nor_gate_core.

Test Plan:
- Truth table, WIDTH=1: apply a,b = 00,01,10,11 with in_valid=1, 10 ns apart.
  - out_comb = 1,0,0,0 immediately.
  - out = 1,0,0,0 one clock later, with out_valid=1 each cycle.
- Vector, WIDTH=8: a=8'hF0, b=8'h0C, valid.
  - Next cycle out=8'h03, out_valid=1.
  - With NOR_GATE_POPCNT_EN, ones_cnt=2.
- Hold: valid a=0,b=0 (out=8'hFF), then in_valid=0 with a=8'hFF.
  - out stays 8'hFF, out_valid=0, out_comb=8'h00.
- Async reset: assert rst between clock edges while out=8'hFF.
  - out=0 and out_valid=0 immediately, before the next edge.
  - Deassert rst and apply valid a=0,b=0: out=8'hFF after 1 cycle.
- Streaming: 16 consecutive random valid pairs.
  - out matches ~(a|b) of the prior cycle every cycle.
  - out_valid stays high throughout.
- Reset/valid same edge: rst deasserts on the same edge that in_valid=1, a=8'h00, b=8'h01.
  - Next edge gives out=8'hFE, out_valid=1.
